pic_host_sequencer: RTL and testbench

Clocked host-side controller for the 8259-style PIC. It drives the PIC's asynchronous CPU pins (`cs_n`, `wr_n`, `rd_n`, `A0`, `INTA`, data bus) from a synchronous core. It performs the ICW1–ICW4/OCW1 initialisation sequence, serialises core register reads and writes, and runs the two-pulse interrupt-acknowledge cycle to return the vector. It sits between the processor core and the PIC instance, and is the single owner of the PIC bus.

---
 rtl/pic_host_pkg.sv | 48 ++++
 rtl/pic_host_sequencer_timer.sv | 29 ++
 rtl/pic_host_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_pic_host_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_host_pkg.sv
// Shared types and constants for the 8259-style PIC host sequencer.
// Holds the FSM state enum, ICW1 bit indices, A0 encodings and init-word helpers.
// No logic of its own; imported by the sequencer top and its timer.
package pic_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_INTA1,
    ST_INTA_GAP,
    ST_INTA2,
    ST_VEC_OUT,
    ST_REARM
  } state_t;

  // ICW1 bit positions
  localparam int IC4  = 0;
  localparam int SNGL = 1;

  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  // Non-specific end-of-interrupt, issued by the core as a plain write
  localparam logic [7:0] OCW2_NS_EOI = 8'h20;

  typedef enum logic [2:0] {
    W_ICW1,
    W_ICW2,
    W_ICW3,
    W_ICW4,
    W_OCW1,
    W_DONE
  } init_word_t;

  // Successor in the init sequence; ICW3 only in cascade mode, ICW4 only when requested.
  function automatic init_word_t next_word(input init_word_t cur, input logic [7:0] icw1);
    case (cur)
      W_ICW1:  next_word = W_ICW2;
      W_ICW2:  next_word = !icw1[SNGL] ? W_ICW3 : (icw1[IC4] ? W_ICW4 : W_OCW1);
      W_ICW3:  next_word = icw1[IC4] ? W_ICW4 : W_OCW1;
      W_ICW4:  next_word = W_OCW1;
      default: next_word = W_DONE;
    endcase
  endfunction

endpackage

// File: rtl/pic_host_sequencer_timer.sv
// Loadable down-counter timing strobe, gap and re-arm phases of the sequencer.
// Latency: load takes effect on the next edge; last is high while the count equals 1.
// No backpressure: counts down to 0 and holds until reloaded.
// Ports: clk, rst_n, load/load_val (reload request and value), last (final cycle of phase).
module pic_strobe_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/pic_host_sequencer.sv
// Host-side controller owning the 8259 CPU bus: init sequence, core register accesses, INTA cycles.
// Latency: access S+3 cycles accept-to-idle, read data at S+2; INTA 2S+R, vector pulse, R re-arm.
// Backpressure: cmd_ready only in IDLE after init with no synchronised interrupt pending.
// Ports: init_* (init words/control), cmd_*/rsp_* (core access), vec_* (acknowledged vector),
//        pic_* (PIC pins: strobes, a0, data out/oe/in), pic_int (async INT request).
module pic_host_sequencer
  import pic_host_pkg::*;
#(
  parameter int STROBE_CYCLES   = 4,
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1_init,
  output logic       init_done,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       pic_int,
  output logic       vec_valid,
  output logic [7:0] vec,
  output logic       pic_cs_n,
  output logic       pic_wr_n,
  output logic       pic_rd_n,
  output logic       pic_inta_n,
  output logic       pic_a0,
  output logic [7:0] pic_d_out,
  output logic       pic_d_oe,
  input  logic [7:0] pic_d_in
);

  localparam int TW = 8;

  state_t     state;
  init_word_t word;
  init_word_t next_w;
  logic [7:0] next_dat;
  logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q;
  logic       init_act;
  logic       is_rd;
  logic       int_meta, int_s;
  logic       tmr_load, tmr_last;
  logic [TW-1:0] tmr_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_meta <= 1'b0;
      int_s    <= 1'b0;
    end else begin
      int_meta <= pic_int;
      int_s    <= int_meta;
    end
  end

  // Ready is formed from registers only. The core must not raise init_start while
  // it has a command pending, since init takes priority in IDLE.
  assign cmd_ready = (state == ST_IDLE) && init_done && !int_s;

  always_comb begin
    next_w = next_word(word, icw1_q);
    case (next_w)
      W_ICW2:  next_dat = icw2_q;
      W_ICW3:  next_dat = icw3_q;
      W_ICW4:  next_dat = icw4_q;
      W_OCW1:  next_dat = ocw1_q;
      default: next_dat = icw1_q;
    endcase
  end

  // Timer reloads on entry to each timed phase, so last marks that phase's final cycle.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TW'(STROBE_CYCLES);
    case (state)
      ST_IDLE:     tmr_load = !init_start && int_s && init_done;
      ST_SETUP:    tmr_load = 1'b1;
      ST_INTA1: begin
        tmr_load = tmr_last;
        tmr_val  = TW'(RECOVERY_CYCLES);
      end
      ST_INTA_GAP: tmr_load = tmr_last;
      ST_VEC_OUT: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(RECOVERY_CYCLES);
      end
      default: ;
    endcase
  end

  pic_strobe_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      word       <= W_ICW1;
      init_act   <= 1'b0;
      is_rd      <= 1'b0;
      icw1_q     <= '0;
      icw2_q     <= '0;
      icw3_q     <= '0;
      icw4_q     <= '0;
      ocw1_q     <= '0;
      init_done  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      vec_valid  <= 1'b0;
      vec        <= '0;
      pic_cs_n   <= 1'b1;
      pic_wr_n   <= 1'b1;
      pic_rd_n   <= 1'b1;
      pic_inta_n <= 1'b1;
      pic_a0     <= 1'b0;
      pic_d_out  <= '0;
      pic_d_oe   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      vec_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (init_start) begin
            icw1_q    <= icw1;
            icw2_q    <= icw2;
            icw3_q    <= icw3;
            icw4_q    <= icw4;
            ocw1_q    <= ocw1_init;
            init_done <= 1'b0;
            init_act  <= 1'b1;
            word      <= W_ICW1;
            is_rd     <= 1'b0;
            state     <= ST_SETUP;
            pic_cs_n  <= 1'b0;
            pic_a0    <= A0_CMD;
            pic_d_out <= icw1;
            pic_d_oe  <= 1'b1;
          end else if (int_s && init_done) begin
            state      <= ST_INTA1;
            pic_inta_n <= 1'b0;
          end else if (cmd_valid && cmd_ready) begin
            is_rd     <= cmd_rd;
            state     <= ST_SETUP;
            pic_cs_n  <= 1'b0;
            pic_a0    <= cmd_a0;
            pic_d_out <= cmd_wdata;
            pic_d_oe  <= !cmd_rd;
          end
        end
        ST_SETUP: begin
          state <= ST_STROBE;
          if (is_rd) pic_rd_n <= 1'b0;
          else       pic_wr_n <= 1'b0;
        end
        ST_STROBE: begin
          if (tmr_last) begin
            state    <= ST_HOLD;
            pic_wr_n <= 1'b1;
            pic_rd_n <= 1'b1;
            if (is_rd) begin
              rsp_rdata <= pic_d_in;
              rsp_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Init words chain straight into the next SETUP with cs_n kept low.
          if (init_act && next_w != W_DONE) begin
            state     <= ST_SETUP;
            word      <= next_w;
            pic_a0    <= A0_DATA;
            pic_d_out <= next_dat;
          end else begin
            state    <= ST_IDLE;
            pic_cs_n <= 1'b1;
            pic_d_oe <= 1'b0;
            if (init_act) begin
              init_act  <= 1'b0;
              init_done <= 1'b1;
            end
          end
        end
        ST_INTA1: begin
          if (tmr_last) begin
            state      <= ST_INTA_GAP;
            pic_inta_n <= 1'b1;
          end
        end
        ST_INTA_GAP: begin
          if (tmr_last) begin
            state      <= ST_INTA2;
            pic_inta_n <= 1'b0;
          end
        end
        ST_INTA2: begin
          if (tmr_last) begin
            state      <= ST_VEC_OUT;
            pic_inta_n <= 1'b1;
            vec        <= pic_d_in;
            vec_valid  <= 1'b1;
          end
        end
        ST_VEC_OUT: state <= ST_REARM;
        ST_REARM: begin
          if (tmr_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Randomised scoreboard bench for pic_host_sequencer.
// Stimulus pushes expected PIC bus events; a negedge monitor reconstructs events and compares.
// Directed timing checks run inline with stimulus.
module tb_pic_host_sequencer;
  import pic_host_pkg::*;

  localparam int S = 4;
  localparam int R = 2;
  localparam int EV_WR = 0, EV_RD = 1, EV_RSP = 2, EV_INTA = 3, EV_VEC = 4;

  typedef struct {
    int         kind;
    logic       a0;
    logic [7:0] data;
    int         len;
    bit         bad;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_start = 1'b0;
  logic [7:0] icw1 = '0, icw2 = '0, icw3 = '0, icw4 = '0, ocw1_init = '0;
  logic       init_done;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_rd = 1'b0, cmd_a0 = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       pic_int = 1'b0;
  logic       vec_valid;
  logic [7:0] vec;
  logic       pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n, pic_a0, pic_d_oe;
  logic [7:0] pic_d_out;
  logic [7:0] pic_d_in = '0;

  int  n_pass = 0;
  int  n_total = 0;
  ev_t exp_q[$];

  pic_host_sequencer #(.STROBE_CYCLES(S), .RECOVERY_CYCLES(R)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1_init(ocw1_init),
    .init_done(init_done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_a0(cmd_a0), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .pic_int(pic_int),
    .vec_valid(vec_valid), .vec(vec), .pic_cs_n(pic_cs_n), .pic_wr_n(pic_wr_n),
    .pic_rd_n(pic_rd_n), .pic_inta_n(pic_inta_n), .pic_a0(pic_a0),
    .pic_d_out(pic_d_out), .pic_d_oe(pic_d_oe), .pic_d_in(pic_d_in)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model: expected bus events ----------------
  function automatic void push_wr(input logic a0, input logic [7:0] d);
    exp_q.push_back('{EV_WR, a0, d, S, 1'b0});
  endfunction

  function automatic void push_rd(input logic a0, input logic [7:0] d);
    exp_q.push_back('{EV_RD, a0, 8'h00, S, 1'b0});
    exp_q.push_back('{EV_RSP, 1'b0, d, 1, 1'b0});
  endfunction

  function automatic void push_int(input logic [7:0] v);
    exp_q.push_back('{EV_INTA, 1'b0, 8'h00, S, 1'b0});
    exp_q.push_back('{EV_INTA, 1'b0, 8'h00, S, 1'b0});
    exp_q.push_back('{EV_VEC, 1'b0, v, 1, 1'b0});
  endfunction

  // Writes ICW1, ICW2, optional ICW3 (cascade), optional ICW4 (IC4 set), OCW1.
  function automatic int model_init(input logic [7:0] w1, w2, w3, w4, o1);
    int n = 3;
    push_wr(1'b0, w1);
    push_wr(1'b1, w2);
    if (w1[1] == 1'b0) begin push_wr(1'b1, w3); n++; end
    if (w1[0] == 1'b1) begin push_wr(1'b1, w4); n++; end
    push_wr(1'b1, o1);
    return n;
  endfunction

  // ---------------- monitor ----------------
  int         wr_len = 0, rd_len = 0, ia_len = 0;
  bit         wr_bad = 0, rd_bad = 0, ia_bad = 0;
  logic       wr_a0, rd_a0;
  logic [7:0] wr_d;

  task automatic mon_event(input ev_t g);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h required no event", g.kind, g.data);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", g.kind, e.kind);
      chk("ev_a0", int'(g.a0), int'(e.a0));
      chk("ev_data", int'(g.data), int'(e.data));
      chk("ev_len", g.len, e.len);
      chk("ev_protocol", int'(g.bad), int'(e.bad));
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      wr_len = 0; rd_len = 0; ia_len = 0;
      wr_bad = 0; rd_bad = 0; ia_bad = 0;
    end else begin
      if (!pic_wr_n) begin
        if (wr_len > 0 && (pic_a0 != wr_a0 || pic_d_out != wr_d)) wr_bad = 1;
        if (pic_cs_n || !pic_d_oe || !pic_rd_n || !pic_inta_n) wr_bad = 1;
        wr_len++; wr_a0 = pic_a0; wr_d = pic_d_out;
      end else if (wr_len > 0) begin
        mon_event('{EV_WR, wr_a0, wr_d, wr_len, wr_bad});
        wr_len = 0; wr_bad = 0;
      end
      if (!pic_rd_n) begin
        if (rd_len > 0 && pic_a0 != rd_a0) rd_bad = 1;
        if (pic_cs_n || pic_d_oe || !pic_inta_n) rd_bad = 1;
        rd_len++; rd_a0 = pic_a0;
      end else if (rd_len > 0) begin
        mon_event('{EV_RD, rd_a0, 8'h00, rd_len, rd_bad});
        rd_len = 0; rd_bad = 0;
      end
      if (!pic_inta_n) begin
        if (!pic_cs_n || pic_d_oe) ia_bad = 1;
        ia_len++;
      end else if (ia_len > 0) begin
        mon_event('{EV_INTA, 1'b0, 8'h00, ia_len, ia_bad});
        ia_len = 0; ia_bad = 0;
      end
      if (rsp_valid) mon_event('{EV_RSP, 1'b0, rsp_rdata, 1, 1'b0});
      if (vec_valid) mon_event('{EV_VEC, 1'b0, vec, 1, 1'b0});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [7:0] w1, w2, w3, w4, o1);
    int n, nw;
    icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4; ocw1_init = o1;
    nw = model_init(w1, w2, w3, w4, o1);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    n = 1;
    while (!init_done && n < 300) begin tick(); n++; end
    chk("init_done_cycle", n, nw * (S + 2) + 1);
  endtask

  task automatic do_cmd(input logic rd, input logic a0, input logic [7:0] d);
    int n, k, rsp_at;
    if (rd) begin pic_d_in = d; push_rd(a0, d); end
    else push_wr(a0, d);
    cmd_rd = rd; cmd_a0 = a0; cmd_wdata = rd ? 8'h00 : d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("cmd_accept_timeout", n, 0);
    tick();
    cmd_valid = 1'b0;
    k = 1; rsp_at = -1;
    while (!cmd_ready && k < 100) begin
      if (rsp_valid && rsp_at < 0) rsp_at = k;
      tick(); k++;
    end
    chk("cmd_idle_cycle", k, S + 3);
    if (rd) chk("rsp_cycle", rsp_at, S + 2);
  endtask

  task automatic do_int(input logic [7:0] v, input bit drop_early);
    int n, m, q;
    pic_d_in = v;
    push_int(v);
    pic_int = 1'b1;
    n = 0;
    while (pic_inta_n && n < 100) begin tick(); n++; end
    chk("inta_latency", n, 3);
    if (drop_early) pic_int = 1'b0;
    m = 0;
    while (!vec_valid && m < 100) begin tick(); m++; end
    chk("vec_cycle", m, 2 * S + R);
    pic_int = 1'b0;
    q = 0;
    while (!cmd_ready && q < 100) begin tick(); q++; end
    chk("rearm_cycles", q, R + 1);
  endtask

  initial begin
    int n;
    logic [7:0] w1, v;
    // Reset values
    repeat (3) tick();
    chk("rst_strobes", {pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n}, 4'hF);
    chk("rst_a0_oe", {pic_a0, pic_d_oe}, 0);
    chk("rst_d_out", pic_d_out, 0);
    chk("rst_flags", {init_done, cmd_ready, rsp_valid, vec_valid}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_vec", vec, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_before_init", cmd_ready, 0);

    // Init without ICW3, with ICW4
    do_init(8'h1B, 8'h75, 8'h00, 8'h02, 8'hC2);
    // Read IRR
    do_cmd(1'b1, A0_CMD, 8'h96);
    // Acknowledge, INT withdrawn once INTA1 has begun
    do_int(8'h74, 1'b1);

    // Contention: command presented while synchronised INT is high
    pic_d_in = 8'h5A;
    push_int(8'h5A);
    push_wr(A0_CMD, OCW2_NS_EOI);
    pic_int = 1'b1;
    tick(); tick();
    cmd_rd = 1'b0; cmd_a0 = A0_CMD; cmd_wdata = OCW2_NS_EOI; cmd_valid = 1'b1;
    chk("contention_ready_low", cmd_ready, 0);
    n = 0;
    while (pic_inta_n && n < 100) begin tick(); n++; end
    pic_int = 1'b0;
    n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    chk("contention_ready_after_inta", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    chk("contention_write_done", n, S + 2);

    // Init with ICW3, no ICW4
    do_init(8'h10, 8'h48, 8'h04, 8'h00, 8'hFF);

    // Randomised mix
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        w1 = 8'($urandom);
        do_init(w1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end else if (r <= 2) begin
        v = 8'($urandom);
        do_int(v, 1'($urandom));
      end else begin
        do_cmd(1'(r <= 5), 1'($urandom), 8'($urandom));
      end
    end

    // Reset during the ICW2 strobe
    icw1 = 8'h1B; icw2 = 8'h75; icw4 = 8'h02; ocw1_init = 8'hC2;
    n = model_init(8'h1B, 8'h75, 8'h00, 8'h02, 8'hC2);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    n = 0;
    while (!(!pic_wr_n && pic_a0) && n < 100) begin tick(); n++; end
    if (n >= 100) chk("icw2_strobe_timeout", n, 0);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    chk("midrst_strobes", {pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n}, 4'hF);
    chk("midrst_oe", pic_d_oe, 0);
    chk("midrst_init_done", init_done, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("no_restart_after_rst", {pic_cs_n, init_done}, 2'b10);
    do_init(8'h1B, 8'h75, 8'h00, 8'h02, 8'hC2);
    do_cmd(1'b0, A0_CMD, OCW2_NS_EOI);
    do_cmd(1'b1, A0_DATA, 8'hC3);

    repeat (10) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
